// File: rtl/qcl_rx16_aligner.sv
// qcl_rx16_aligner: half-cycle word aligner for a 16-bit DDR receive path.
// Locks onto a repeating training word and then forwards aligned payload.
module qcl_rx16_aligner #(
    parameter logic [31:0] train_pattern_p = 32'hF0E1_3C5A,
    parameter int unsigned lock_cnt_p      = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] data_par_i,
    input  logic        realign_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        locked_o,
    output logic        offset_o,
    output logic [7:0]  retry_cnt_o
);

    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [7:0] lock_cnt = 8'(lock_cnt_p);

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic        offset;
    logic        offset_n;
    logic [7:0]  match_cnt;
    logic [7:0]  match_cnt_n;
    logic [7:0]  retry_n;
    logic [15:0] prev_f;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [31:0] w;
    logic        w_hit;

    // Both half-cycle candidates; C1 pairs the previous falling sample
    // with the current rising sample.
    assign c0    = data_par_i;
    assign c1    = {data_par_i[15:0], prev_f};
    assign w     = offset ? c1 : c0;
    assign w_hit = (w == train_pattern_p);

    // Alignment search / verify / lock decisions.
    always_comb begin
        state_n     = state;
        offset_n    = offset;
        match_cnt_n = match_cnt;
        retry_n     = retry_cnt_o;
        if (realign_i) begin
            state_n     = SEARCH;
            match_cnt_n = 8'd0;
        end else begin
            case (state)
                SEARCH: begin
                    if (c0 == train_pattern_p) begin
                        offset_n    = 1'b0;
                        match_cnt_n = 8'd1;
                        state_n     = VERIFY;
                    end else if (c1 == train_pattern_p) begin
                        offset_n    = 1'b1;
                        match_cnt_n = 8'd1;
                        state_n     = VERIFY;
                    end
                end
                VERIFY: begin
                    if (w_hit) begin
                        match_cnt_n = match_cnt + 8'd1;
                        if (match_cnt + 8'd1 == lock_cnt) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        state_n     = SEARCH;
                        match_cnt_n = 8'd0;
                        if (retry_cnt_o != 8'hFF) begin
                            retry_n = retry_cnt_o + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    state_n = LOCKED;
                end
                default: begin
                    state_n     = SEARCH;
                    match_cnt_n = 8'd0;
                end
            endcase
        end
    end

    // State, alignment bookkeeping and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= SEARCH;
            offset      <= 1'b0;
            match_cnt   <= 8'd0;
            retry_cnt_o <= 8'd0;
            prev_f      <= 16'd0;
            data_o      <= 32'd0;
            valid_o     <= 1'b0;
            locked_o    <= 1'b0;
        end else begin
            state       <= state_n;
            offset      <= offset_n;
            match_cnt   <= match_cnt_n;
            retry_cnt_o <= retry_n;
            prev_f      <= data_par_i[31:16];
            data_o      <= w;
            valid_o     <= (state_n == LOCKED) && !w_hit;
            locked_o    <= (state_n == LOCKED);
        end
    end

    assign offset_o = offset;

endmodule

// File: tb/tb_qcl_rx16_aligner.sv
// tb_qcl_rx16_aligner: directed checks of lock, offset, filtering,
// realign, reset and retry saturation.
module tb_qcl_rx16_aligner;

    localparam logic [31:0] PAT = 32'hF0E1_3C5A;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] data_par_i;
    logic        realign_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        locked_o;
    logic        offset_o;
    logic [7:0]  retry_cnt_o;

    int errors = 0;
    int checks = 0;

    qcl_rx16_aligner dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .data_par_i  (data_par_i),
        .realign_i   (realign_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .locked_o    (locked_o),
        .offset_o    (offset_o),
        .retry_cnt_o (retry_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock with the given input word; outputs sampled 1 after the edge.
    task automatic cyc(input logic [31:0] d, input logic rl);
        data_par_i = d;
        realign_i  = rl;
        @(posedge clk);
        #1;
        realign_i  = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        cyc(32'd0, 1'b0);
        reset_i = 1'b0;
    endtask

    logic [31:0] filt_d [5];
    logic        filt_v [5];
    logic [31:0] lw [20];

    initial begin
        reset_i    = 1'b1;
        realign_i  = 1'b0;
        data_par_i = 32'd0;
        do_reset();
        check("rst_data", data_o, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_locked", {31'd0, locked_o}, 32'd0);
        check("rst_offset", {31'd0, offset_o}, 32'd0);
        check("rst_retry", {24'd0, retry_cnt_o}, 32'd0);

        // Broken training: 5 good words then a corrupt one, three times.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) cyc(PAT, 1'b0);
            check("brk_5_nolock", {31'd0, locked_o}, 32'd0);
            cyc(32'd0, 1'b0);
            check("brk_retry", {24'd0, retry_cnt_o}, r + 1);
        end
        check("brk_nolock", {31'd0, locked_o}, 32'd0);

        // Offset 0 lock after 16 training words.
        for (int i = 0; i < 15; i++) cyc(PAT, 1'b0);
        check("o0_15_nolock", {31'd0, locked_o}, 32'd0);
        cyc(PAT, 1'b0);
        check("o0_locked", {31'd0, locked_o}, 32'd1);
        check("o0_offset", {31'd0, offset_o}, 32'd0);
        check("o0_train_nv", {31'd0, valid_o}, 32'd0);
        cyc(32'h1234_5678, 1'b0);
        check("o0_data", data_o, 32'h1234_5678);
        check("o0_valid", {31'd0, valid_o}, 32'd1);
        check("o0_retry", {24'd0, retry_cnt_o}, 32'd3);

        // Training words interleaved with payload are filtered out.
        filt_d = '{32'hAAAA_0001, PAT, 32'hBBBB_0002, PAT, 32'hCCCC_0003};
        filt_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            cyc(filt_d[i], 1'b0);
            check("flt_data", data_o, filt_d[i]);
            check("flt_valid", {31'd0, valid_o}, {31'd0, filt_v[i]});
            check("flt_locked", {31'd0, locked_o}, 32'd1);
        end

        // Realign drops lock without counting a retry, then relocks.
        cyc(32'h5555_6666, 1'b1);
        check("rl_unlock", {31'd0, locked_o}, 32'd0);
        check("rl_valid", {31'd0, valid_o}, 32'd0);
        check("rl_retry", {24'd0, retry_cnt_o}, 32'd3);
        for (int i = 0; i < 15; i++) cyc(PAT, 1'b0);
        check("rl_15_nolock", {31'd0, locked_o}, 32'd0);
        cyc(PAT, 1'b0);
        check("rl_relock", {31'd0, locked_o}, 32'd1);

        // Realign together with a verify mismatch: no retry increment.
        cyc(32'd0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(PAT, 1'b0);
        cyc(32'd0, 1'b1);
        check("rlmm_retry", {24'd0, retry_cnt_o}, 32'd3);
        check("rlmm_unlock", {31'd0, locked_o}, 32'd0);

        // Offset 1: logical words carried half a cycle late.
        do_reset();
        for (int i = 0; i < 17; i++) lw[i] = PAT;
        lw[17] = 32'hCAFE_BABE;
        lw[18] = 32'h0BAD_F00D;
        lw[19] = 32'd0;
        for (int t = 0; t < 19; t++) begin
            cyc({lw[t+1][15:0], lw[t][31:16]}, 1'b0);
            if (t == 15) check("o1_15_nolock", {31'd0, locked_o}, 32'd0);
            if (t == 16) begin
                check("o1_locked", {31'd0, locked_o}, 32'd1);
                check("o1_offset", {31'd0, offset_o}, 32'd1);
            end
            if (t >= 17) begin
                check("o1_data", data_o, lw[t]);
                check("o1_valid", {31'd0, valid_o}, 32'd1);
            end
        end

        // Reset while locked clears every output on the next edge.
        reset_i = 1'b1;
        cyc(32'h7777_8888, 1'b0);
        reset_i = 1'b0;
        check("mrst_data", data_o, 32'd0);
        check("mrst_valid", {31'd0, valid_o}, 32'd0);
        check("mrst_locked", {31'd0, locked_o}, 32'd0);
        check("mrst_offset", {31'd0, offset_o}, 32'd0);
        check("mrst_retry", {24'd0, retry_cnt_o}, 32'd0);

        // 300 failed attempts saturate the retry counter.
        for (int a = 1; a <= 300; a++) begin
            cyc(PAT, 1'b0);
            cyc(32'd0, 1'b0);
            if (a == 10) check("sat_10", {24'd0, retry_cnt_o}, 32'd10);
            if (a == 255) check("sat_255", {24'd0, retry_cnt_o}, 32'd255);
        end
        check("sat_300", {24'd0, retry_cnt_o}, 32'd255);
        check("sat_nolock", {31'd0, locked_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
